// File: rtl/servo_pwm_channel.sv
// Avalon-MM hobby-servo PWM channel: µs timebase, clamped pulse width applied only
// at frame boundaries, sticky frame flag for software synchronisation.
module servo_pwm_channel #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned PERIOD_US  = 20000,
    parameter int unsigned MIN_US     = 500,
    parameter int unsigned MAX_US     = 2500,
    parameter int unsigned DEFAULT_US = 1500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        servo_out
);

    localparam int unsigned DIV   = CLK_HZ / 1000000;
    localparam int unsigned PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PULSE  = 2'd1;
    localparam logic [1:0] ADDR_ACTIVE = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    logic [PS_W-1:0]  ps_q, ps_d;
    logic [CNT_W-1:0] us_cnt_q, us_cnt_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic             en_q, en_d;
    logic             run_q, run_d;
    logic             frame_q, frame_d;
    logic             servo_q, servo_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             tick_c;
    logic             boundary_c;
    logic [15:0]      wd_us_c;
    logic [15:0]      clamp_c;
    logic             unused_wd;

    assign unused_wd = ^avs_writedata[31:16];

    always_comb begin
        ps_d       = ps_q;
        us_cnt_d   = us_cnt_q;
        pending_d  = pending_q;
        active_d   = active_q;
        en_d       = en_q;
        run_d      = run_q;
        frame_d    = frame_q;
        rdata_d    = rdata_q;
        tick_c     = (ps_q == PS_W'(DIV - 1));
        boundary_c = tick_c && (us_cnt_q == CNT_W'(PERIOD_US - 1));
        wd_us_c    = avs_writedata[15:0];
        clamp_c    = wd_us_c;

        if (wd_us_c < 16'(MIN_US)) begin
            clamp_c = 16'(MIN_US);
        end else if (wd_us_c > 16'(MAX_US)) begin
            clamp_c = 16'(MAX_US);
        end

        // Free-running µs timebase, independent of EN
        if (tick_c) begin
            ps_d     = '0;
            us_cnt_d = boundary_c ? '0 : us_cnt_q + CNT_W'(1);
        end else begin
            ps_d = ps_q + PS_W'(1);
        end

        if (avs_write) begin
            case (avs_address)
                ADDR_CTRL:   en_d      = avs_writedata[0];
                ADDR_PULSE:  pending_d = CNT_W'(clamp_c);
                ADDR_STATUS: if (avs_writedata[0]) frame_d = 1'b0;
                default:     ;
            endcase
        end

        // Clearing EN also drops run so a mid-frame re-enable waits for a boundary
        run_d = run_q & en_d;
        if (boundary_c) begin
            active_d = pending_q;
            run_d    = en_q;
            frame_d  = 1'b1;
        end

        servo_d = run_q & en_q & (us_cnt_q < active_q);

        if (avs_read) begin
            case (avs_address)
                ADDR_CTRL:   rdata_d = {31'd0, en_q};
                ADDR_PULSE:  rdata_d = 32'(pending_q);
                ADDR_ACTIVE: rdata_d = 32'(active_q);
                ADDR_STATUS: rdata_d = {31'd0, frame_q};
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ps_q      <= '0;
            us_cnt_q  <= '0;
            pending_q <= CNT_W'(DEFAULT_US);
            active_q  <= CNT_W'(DEFAULT_US);
            en_q      <= 1'b0;
            run_q     <= 1'b0;
            frame_q   <= 1'b0;
            servo_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ps_q      <= ps_d;
            us_cnt_q  <= us_cnt_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            en_q      <= en_d;
            run_q     <= run_d;
            frame_q   <= frame_d;
            servo_q   <= servo_d;
            rdata_q   <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign servo_out    = servo_q;

endmodule

// File: tb/tb_servo_pwm_channel.sv
// Scoreboard bench for servo_pwm_channel at 2 MHz / 2600 µs frames so that
// several whole frames fit in a short run.
module tb_servo_pwm_channel;

    localparam int unsigned CLK_HZ = 2000000;
    localparam int unsigned PER_US = 2600;
    localparam int F = 5200;

    typedef struct { int start; int width; } pulse_t;
    typedef struct { string tag; logic [31:0] val; } rd_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        servo_out;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     ecnt    = 0;
    logic   rd_pend = 1'b0;
    pulse_t pulse_q[$];
    rd_t    rd_exp_q[$];

    servo_pwm_channel #(
        .CLK_HZ(CLK_HZ), .PERIOD_US(PER_US), .MIN_US(500), .MAX_US(2500), .DEFAULT_US(1500)
    ) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .servo_out(servo_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edges seen with reset released; mirrors where the frame boundaries fall
    always @(posedge clk) begin
        ecnt    <= reset_n ? ecnt + 1 : 0;
        rd_pend <= avs_read;
    end

    always @(negedge clk) begin
        rd_t r;
        if (rd_pend) begin
            if (rd_exp_q.size() == 0) begin
                check_eq("rd_unexpected", 32'd1, 32'd0);
            end else begin
                r = rd_exp_q.pop_front();
                check_eq(r.tag, avs_readdata, r.val);
            end
        end
    end

    int hi_start = 0;
    int hi_len   = 0;
    bit hi       = 1'b0;
    always @(negedge clk) begin
        pulse_t p;
        if (servo_out === 1'b1) begin
            if (!hi) begin
                hi       = 1'b1;
                hi_start = ecnt;
                hi_len   = 0;
            end
            hi_len++;
        end else if (hi) begin
            hi = 1'b0;
            if (pulse_q.size() == 0) begin
                check_eq("pulse_unexpected", 32'(hi_start), 32'd0);
            end else begin
                p = pulse_q.pop_front();
                check_eq("pulse_start", 32'(hi_start), 32'(p.start));
                check_eq("pulse_width", 32'(hi_len), 32'(p.width));
            end
        end
    end

    task automatic wait_edge(input int t);
        while (ecnt < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
        rd_exp_q.push_back('{tag, exp});
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_servo", 32'(servo_out), 32'd0);
        check_eq("rst_rdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        bus_read(2'd0, "rst_ctrl", 32'd0);
        bus_read(2'd1, "rst_pulse", 32'd1500);
        bus_read(2'd2, "rst_active", 32'd1500);
        bus_read(2'd3, "rst_status", 32'd0);

        // Two full frames with EN=0: no pulse is expected, FRAME has set
        wait_edge(2*F + 100);
        bus_read(2'd3, "frame_set_f2", 32'd1);
        bus_write(2'd3, 32'd1);
        bus_read(2'd3, "frame_clr", 32'd0);
        bus_write(2'd0, 32'd1);
        bus_read(2'd0, "ctrl_en", 32'd1);
        pulse_q.push_back('{3*F + 1, 3000});
        pulse_q.push_back('{4*F + 1, 3000});

        wait_edge(3*F + 100);
        bus_read(2'd3, "frame_set_f3", 32'd1);
        bus_write(2'd3, 32'd1);
        wait_edge(4*F + 100);
        bus_read(2'd3, "frame_set_f4", 32'd1);

        // Update while the pulse is high: current pulse unaffected
        wait_edge(4*F + 1000);
        bus_write(2'd1, 32'd2000);
        bus_read(2'd1, "pulse_pending", 32'd2000);
        bus_read(2'd2, "active_pre", 32'd1500);
        pulse_q.push_back('{5*F + 1, 4000});
        wait_edge(5*F + 100);
        bus_read(2'd2, "active_post", 32'd2000);

        bus_write(2'd1, 32'd3000);
        bus_read(2'd1, "clamp_hi", 32'd2500);
        bus_write(2'd1, 32'd100);
        bus_read(2'd1, "clamp_lo", 32'd500);
        bus_write(2'd1, 32'h0001_07D0);
        bus_read(2'd1, "clamp_upper_ign", 32'd2000);

        // Disable sampled at edge 6F+500 truncates the pulse to 500 cycles
        pulse_q.push_back('{6*F + 1, 500});
        wait_edge(6*F + 499);
        bus_write(2'd0, 32'd0);
        @(posedge clk);
        #1;
        check_eq("dis_low", 32'(servo_out), 32'd0);
        wait_edge(6*F + 999);
        bus_write(2'd0, 32'd1);
        wait_edge(6*F + 1500);
        check_eq("reen_wait", 32'(servo_out), 32'd0);
        pulse_q.push_back('{7*F + 1, 4000});
        pulse_q.push_back('{8*F + 1, 4000});
        pulse_q.push_back('{9*F + 1, 2000});

        // PULSE_US write landing on the boundary edge
        wait_edge(8*F - 1);
        bus_write(2'd1, 32'd1000);
        bus_read(2'd1, "coll_pending", 32'd1000);
        bus_read(2'd2, "coll_active_old", 32'd2000);
        bus_write(2'd3, 32'd1);
        bus_read(2'd3, "frame_clr2", 32'd0);

        // STATUS W1C landing on the boundary edge: set wins
        wait_edge(9*F - 1);
        bus_write(2'd3, 32'd1);
        bus_read(2'd3, "coll_frame_set", 32'd1);
        bus_read(2'd2, "coll_active_new", 32'd1000);

        wait_edge(9*F + 2300);
        check_eq("pulses_left", 32'(pulse_q.size()), 32'd0);
        check_eq("reads_left", 32'(rd_exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
